// File: rtl/bcd_seg_scan_if.sv
// Bus between the BCD adder side and the 2-digit scanned display driver.
// Ports: load/digit_1/digit_0 toward the driver; seg/dig_sel/load_ack/err back.
interface bcd_seg_scan_if;
  logic       load;
  logic [3:0] digit_1;
  logic [3:0] digit_0;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       load_ack;
  logic       err;

  modport master (
    output load, digit_1, digit_0,
    input  seg, dig_sel, load_ack, err
  );

  modport slave (
    input  load, digit_1, digit_0,
    output seg, dig_sel, load_ack, err
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Captures a BCD digit pair and scans it onto a 2-digit common-anode display.
// Ports: clk, rst_n (async active-low), bus (slave: load/digits in, seg/dig_sel/ack/err out).
module bcd_seg_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int BLANK_CYC       = 16,
  parameter int LEAD_ZERO_BLANK = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_seg_scan_if.slave   bus
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] D_LOAD = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] G_LOAD =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  localparam logic [1:0] S_D0 = 2'd0;
  localparam logic [1:0] S_G0 = 2'd1;
  localparam logic [1:0] S_D1 = 2'd2;
  localparam logic [1:0] S_G1 = 2'd3;

  logic [1:0]    st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    sh1, sh0;
  logic [6:0]    seg_q, seg_nx;
  logic [1:0]    sel_q, sel_nx;
  logic          ack_q, err_q;
  logic          tens_dark;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h06;
    endcase
    return s;
  endfunction

  // Slot sequencer: counter reloads on every state entry.
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt - CW'(1);
    if (cnt == '0) begin
      case (st)
        S_D0: begin
          if (BLANK_CYC == 0) begin
            st_nx  = S_D1;
            cnt_nx = D_LOAD;
          end else begin
            st_nx  = S_G0;
            cnt_nx = G_LOAD;
          end
        end
        S_G0: begin
          st_nx  = S_D1;
          cnt_nx = D_LOAD;
        end
        S_D1: begin
          if (BLANK_CYC == 0) begin
            st_nx  = S_D0;
            cnt_nx = D_LOAD;
          end else begin
            st_nx  = S_G1;
            cnt_nx = G_LOAD;
          end
        end
        default: begin
          st_nx  = S_D0;
          cnt_nx = D_LOAD;
        end
      endcase
    end
  end

  // An invalid tens digit must stay visible, so only a true 0 darkens.
  assign tens_dark = (LEAD_ZERO_BLANK != 0) && (sh1 == 4'd0);

  always_comb begin
    sel_nx = 2'b11;
    seg_nx = 7'h7F;
    unique case (1'b1)
      (st == S_D0): begin
        sel_nx = 2'b10;
        seg_nx = dec(sh0);
      end
      (st == S_D1) && !tens_dark: begin
        sel_nx = 2'b01;
        seg_nx = dec(sh1);
      end
      default: begin
        sel_nx = 2'b11;
        seg_nx = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= S_D0;
      cnt   <= D_LOAD;
      sh1   <= 4'd0;
      sh0   <= 4'd0;
      seg_q <= 7'h7F;
      sel_q <= 2'b11;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      seg_q <= seg_nx;
      sel_q <= sel_nx;
      ack_q <= bus.load;
      if (bus.load) begin
        sh1   <= bus.digit_1;
        sh0   <= bus.digit_0;
        err_q <= (bus.digit_1 > 4'd9) || (bus.digit_0 > 4'd9);
      end
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dig_sel  = sel_q;
  assign bus.load_ack = ack_q;
  assign bus.err      = err_q;

endmodule
